spi_cfg_master: RTL

- Command-driven SPI mode-0 master that sequences write frames into the on-chip SPI register peripheral (enable registers 0x00–0x03, PWM duty 0x04).
- Lets on-chip logic (boot sequencer, test controller) configure the peripheral over the same nCS/SCLK/COPI pins that an external host uses.
- Buffers write commands in a small FIFO and serialises each into one 16-bit frame, with a programmable SCLK rate and inter-frame nCS gap.

---
 rtl/spi_cfg_pkg.sv | 25 ++
 rtl/cfg_cmd_fifo.sv | 52 +++++
 rtl/spi_cfg_master.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration master.
// Frame layout: write flag, 7-bit register address, 8-bit data.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_TAIL,
    ST_GAP
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int CMD_W = FRAME_BITS - 1;
  localparam logic WRITE_BIT = 1'b1;
  localparam logic [6:0] MAX_ADDR = 7'h04;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY = 7'h04;

endpackage

// File: rtl/cfg_cmd_fifo.sv
// Command FIFO holding {addr,data} write requests.
// Power-of-2 depth; a count register separates full from empty.
module cfg_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [W-1:0]   wdata,
  input  logic           pop,
  output logic [W-1:0]   rdata,
  output logic           full,
  output logic           empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI mode-0 write master: drains the command FIFO into 16-bit
// frames with programmable SCLK half-period and nCS gap.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
  output logic       frame_done,
  output logic       err_addr
);

  localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNTW = $clog2(CMAX + 1);
  localparam logic [CNTW-1:0] DIV_END = CNTW'(CLK_DIV - 1);
  localparam logic [CNTW-1:0] GAP_END = CNTW'(CS_GAP - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [3:0] bit_cnt, bit_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic ncs_q, ncs_n;
  logic sclk_q, sclk_n;
  logic err_q;

  logic [CMD_W-1:0] fifo_rd;
  logic fifo_full;
  logic fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic accept;
  logic addr_ok;
  logic push;
  logic pop;
  logic half_end;

  assign cmd_ready = !fifo_full;
  assign accept    = cmd_valid && cmd_ready;
  assign addr_ok   = (cmd_addr <= MAX_ADDR);
  assign push      = accept && addr_ok;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign half_end  = (cnt == DIV_END);

  cfg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({cmd_addr, cmd_data}),
    .pop   (pop),
    .rdata (fifo_rd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    ncs_n   = ncs_q;
    sclk_n  = sclk_q;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          shreg_n = {WRITE_BIT, fifo_rd};
          bit_n   = '0;
          ncs_n   = 1'b0;
          state_n = ST_SETUP;
        end
      end
      ST_SETUP, ST_LOW: begin
        cnt_n = cnt + 1'b1;
        if (half_end) begin
          cnt_n   = '0;
          sclk_n  = 1'b1;
          state_n = ST_HIGH;
        end
      end
      ST_HIGH: begin
        cnt_n = cnt + 1'b1;
        if (half_end) begin
          cnt_n  = '0;
          sclk_n = 1'b0;
          if (bit_cnt == LAST_BIT) begin
            state_n = ST_TAIL;
          end else begin
            // next bit appears while SCLK falls
            shreg_n = shreg << 1;
            bit_n   = bit_cnt + 4'd1;
            state_n = ST_LOW;
          end
        end
      end
      ST_TAIL: begin
        cnt_n = cnt + 1'b1;
        if (half_end) begin
          cnt_n   = '0;
          ncs_n   = 1'b1;
          shreg_n = '0;
          state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == GAP_END) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      ncs_q   <= ncs_n;
      sclk_q  <= sclk_n;
      err_q   <= accept && !addr_ok;
    end
  end

  assign nCS        = ncs_q;
  assign SCLK       = sclk_q;
  assign COPI       = shreg[FRAME_BITS-1];
  assign err_addr   = err_q;
  assign frame_done = (state == ST_GAP) && (cnt == GAP_END);
  assign busy       = (state != ST_IDLE) || (fifo_cnt != '0);

endmodule
